// File: rtl/alu_seq_pkg.sv
// Shared definitions for the byte-stream sequential ALU: opcodes, FSM state
// encoding, flag bit positions and small flag helpers.
package alu_seq_pkg;

    // Opcodes, latched from the first A beat of a transaction.
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

    // Bit positions inside the 4-bit {Z,N,C,V} flags vector.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Assemble the flags vector from its individual bits.
    function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    // Signed overflow of A+B: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow of A-B: operands differ in sign, result sign differs from A.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                     input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier returning the low WIDTH bits of a*b.
// The start cycle already performs the first partial-product step, so the
// product is complete after WIDTH enabled cycles and done pulses on the
// cycle following the last step.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [CW-1:0]    step_r;
    logic             run_r;
    logic             done_r;

    // Shift-add datapath: one multiplier bit consumed per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            step_r   <= '0;
            run_r    <= 1'b0;
            done_r   <= 1'b0;
        end else if (ena) begin
            done_r <= 1'b0;
            if (start) begin
                acc_r    <= b[0] ? a : '0;
                mcand_r  <= {a[WIDTH-2:0], 1'b0};
                mplier_r <= {1'b0, b[WIDTH-1:1]};
                step_r   <= CW'(1);
                run_r    <= 1'b1;
            end else if (run_r) begin
                acc_r    <= acc_r + (mplier_r[0] ? mcand_r : '0);
                mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
                mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                step_r   <= step_r + CW'(1);
                if (step_r == LAST_STEP) begin
                    run_r  <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign product = acc_r;
    assign done    = done_r;

endmodule

// File: rtl/alu_seq_bytestream.sv
// Multi-cycle integer ALU fed by an 8-bit valid/ready byte stream.
// Operands A then B arrive little-endian, the opcode executes (single cycle,
// or WIDTH cycles for MUL) and the result is streamed back LSB-first.
module alu_seq_bytestream
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] op,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] flags,
    output logic       busy
);

    localparam int NB = WIDTH / 8;
    localparam int SW = $clog2(WIDTH);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] r_r;
    logic [2:0]       op_r;
    logic [3:0]       flags_r;
    logic             in_rdy_r;
    logic             out_vld_r;
    logic             busy_r;

    logic             in_fire_s;
    logic             out_fire_s;
    logic             last_beat_s;
    logic [WIDTH-1:0] a_shift_s;
    logic [WIDTH-1:0] b_shift_s;
    logic             mul_start_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_prod_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [SW-1:0]    shamt_s;
    logic [WIDTH-1:0] alu_r_s;
    logic             alu_c_s;
    logic             alu_v_s;
    logic [3:0]       alu_flags_s;
    logic [3:0]       mul_flags_s;

    // Stream handshakes are gated by ena so a frozen block neither accepts nor offers data.
    assign in_ready    = in_rdy_r & ena;
    assign out_valid   = out_vld_r & ena;
    assign out_data    = r_r[7:0];
    assign flags       = flags_r;
    assign busy        = busy_r;

    assign in_fire_s   = in_valid & in_ready;
    assign out_fire_s  = out_valid & out_ready;
    assign last_beat_s = (cnt_r == LAST_BEAT);

    // New bytes enter at the top so that after NB beats the first byte sits at bit 0.
    generate
        if (WIDTH > 8) begin : g_wide
            assign a_shift_s = {in_data, a_r[WIDTH-1:8]};
            assign b_shift_s = {in_data, b_r[WIDTH-1:8]};
        end else begin : g_byte
            assign a_shift_s = in_data;
            assign b_shift_s = in_data;
        end
    endgenerate

    // The multiplier starts on the final B beat using the fully assembled B operand.
    assign mul_start_s = in_fire_s & (state_r == LOAD_B) & last_beat_s & (op_r == OP_MUL);

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (mul_start_s),
        .a       (a_r),
        .b       (b_shift_s),
        .product (mul_prod_s),
        .done    (mul_done_s)
    );

    // Single-cycle operations and their flags, evaluated from the loaded operands.
    always_comb begin
        sum_s   = {1'b0, a_r} + {1'b0, b_r};
        diff_s  = {1'b0, a_r} - {1'b0, b_r};
        shamt_s = b_r[SW-1:0];
        alu_r_s = '0;
        alu_c_s = 1'b0;
        alu_v_s = 1'b0;
        case (op_r)
            OP_ADD: begin
                alu_r_s = sum_s[WIDTH-1:0];
                alu_c_s = sum_s[WIDTH];
                alu_v_s = add_ovf(a_r[WIDTH-1], b_r[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r_s = diff_s[WIDTH-1:0];
                alu_c_s = diff_s[WIDTH];
                alu_v_s = sub_ovf(a_r[WIDTH-1], b_r[WIDTH-1], diff_s[WIDTH-1]);
            end
            OP_AND:  alu_r_s = a_r & b_r;
            OP_OR:   alu_r_s = a_r | b_r;
            OP_XOR:  alu_r_s = a_r ^ b_r;
            OP_SHL:  alu_r_s = a_r << shamt_s;
            OP_SHR:  alu_r_s = a_r >> shamt_s;
            default: alu_r_s = '0;
        endcase
        alu_flags_s = pack_flags(alu_r_s == '0, alu_r_s[WIDTH-1], alu_c_s, alu_v_s);
        mul_flags_s = pack_flags(mul_prod_s == '0, mul_prod_s[WIDTH-1], 1'b0, 1'b0);
    end

    // Transaction sequencer with registered handshake, busy, result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            r_r       <= '0;
            op_r      <= OP_ADD;
            flags_r   <= 4'b0000;
            in_rdy_r  <= 1'b1;
            out_vld_r <= 1'b0;
            busy_r    <= 1'b0;
        end else if (ena) begin
            case (state_r)
                IDLE: begin
                    if (in_fire_s) begin
                        a_r    <= a_shift_s;
                        op_r   <= op;
                        busy_r <= 1'b1;
                        if (last_beat_s) begin
                            state_r <= LOAD_B;
                            cnt_r   <= '0;
                        end else begin
                            state_r <= LOAD_A;
                            cnt_r   <= cnt_r + CW'(1);
                        end
                    end
                end
                LOAD_A: begin
                    if (in_fire_s) begin
                        a_r <= a_shift_s;
                        if (last_beat_s) begin
                            state_r <= LOAD_B;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r   <= cnt_r + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (in_fire_s) begin
                        b_r <= b_shift_s;
                        if (last_beat_s) begin
                            state_r  <= EXEC;
                            cnt_r    <= '0;
                            in_rdy_r <= 1'b0;
                        end else begin
                            cnt_r    <= cnt_r + CW'(1);
                        end
                    end
                end
                EXEC: begin
                    if (op_r != OP_MUL) begin
                        r_r       <= alu_r_s;
                        flags_r   <= alu_flags_s;
                        state_r   <= SEND;
                        out_vld_r <= 1'b1;
                    end else if (mul_done_s) begin
                        r_r       <= mul_prod_s;
                        flags_r   <= mul_flags_s;
                        state_r   <= SEND;
                        out_vld_r <= 1'b1;
                    end
                end
                SEND: begin
                    if (out_fire_s) begin
                        r_r <= r_r >> 4'd8;
                        if (last_beat_s) begin
                            state_r   <= IDLE;
                            cnt_r     <= '0;
                            out_vld_r <= 1'b0;
                            in_rdy_r  <= 1'b1;
                            busy_r    <= 1'b0;
                        end else begin
                            cnt_r     <= cnt_r + CW'(1);
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= '0;
                    in_rdy_r  <= 1'b1;
                    out_vld_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_bytestream.sv
// Self-checking bench for alu_seq_bytestream: a WIDTH=32 instance driven from
// a vector table with a byte scoreboard, hand sequences for backpressure,
// enable freeze and mid-multiply reset, plus a WIDTH=8 instance.
module tb_alu_seq_bytestream;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] flags;
    logic       busy;

    logic       ena8;
    logic [7:0] in_data8;
    logic       in_valid8;
    logic       in_ready8;
    logic [2:0] op8;
    logic [7:0] out_data8;
    logic       out_valid8;
    logic       out_ready8;
    logic [3:0] flags8;
    logic       busy8;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic [3:0] flags;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
    } vec_t;
    vec_t vecs[13];

    alu_seq_bytestream #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .flags(flags), .busy(busy)
    );

    alu_seq_bytestream #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena8),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
        .flags(flags8), .busy(busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Scoreboard: every output beat transferred is compared with the next expected byte.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                timeout_fail("unexpected_out_beat");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("out_data", {24'h0, out_data}, {24'h0, e.data});
                chk("flags", {28'h0, flags}, {28'h0, e.flags});
                chk("in_ready_in_send", {31'h0, in_ready}, 32'h0);
            end
        end
    end

    task automatic drive_beat(input logic [7:0] d, input logic [2:0] o);
        int g;
        in_data  = d;
        op       = o;
        in_valid = 1'b1;
        g = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            g++;
            if (g > 200) begin
                timeout_fail("in_ready_wait");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.data  = v.r[8*i +: 8];
            e.flags = v.f;
            sb_q.push_back(e);
        end
    endtask

    task automatic send_txn(input vec_t v);
        push_exp(v);
        for (int i = 0; i < 4; i++) drive_beat(v.a[8*i +: 8], (i == 0) ? v.op : ~v.op);
        for (int i = 0; i < 4; i++) drive_beat(v.b[8*i +: 8], ~v.op);
        last_cyc = cyc;
    endtask

    // Wait for the first result beat while offering junk input that must be ignored.
    task automatic wait_out(output int lat);
        int g;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        op       = 3'd3;
        g   = 0;
        lat = -1;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - last_cyc + 1;
                break;
            end
            g++;
            if (g > 200) begin
                timeout_fail("out_valid_wait");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        forever begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
            g++;
            if (g > 200) begin
                timeout_fail("drain_wait");
                sb_q.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("busy_after_send", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   g;
        vec_t v;

        vecs[0]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 2};
        vecs[1]  = '{OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 2};
        vecs[2]  = '{OP_MUL, 32'h00010001, 32'h00010001, 32'h00020001, 4'b0000, 33};
        vecs[3]  = '{OP_SHL, 32'h0000000F, 32'h00000024, 32'h000000F0, 4'b0000, 2};
        vecs[4]  = '{OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000, 2};
        vecs[5]  = '{OP_OR,  32'h80000000, 32'h00000001, 32'h80000001, 4'b0100, 2};
        vecs[6]  = '{OP_XOR, 32'h12345678, 32'h12345678, 32'h00000000, 4'b1000, 2};
        vecs[7]  = '{OP_SHR, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000, 2};
        vecs[8]  = '{OP_SUB, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b0110, 2};
        vecs[9]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 2};
        vecs[10] = '{OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 33};
        vecs[11] = '{OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000, 2};
        vecs[12] = '{OP_ADD, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 2};

        rst_n      = 1'b0;
        ena        = 1'b1;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        op         = 3'd0;
        out_ready  = 1'b1;
        ena8       = 1'b1;
        in_data8   = 8'h00;
        in_valid8  = 1'b0;
        op8        = 3'd0;
        out_ready8 = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_out_data", {24'h0, out_data}, 32'h0);
        chk("rst_flags", {28'h0, flags}, 32'h0);
        chk("rst_in_ready8", {31'h0, in_ready8}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven operations
        for (int i = 0; i < 13; i++) begin
            send_txn(vecs[i]);
            wait_out(lat);
            chk("latency", lat, vecs[i].lat);
            drain();
        end

        // Backpressure: hold after first beat of 0x11223344
        v = '{OP_ADD, 32'h11223300, 32'h00000044, 32'h11223344, 4'b0000, 2};
        send_txn(v);
        wait_out(lat);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_data", {24'h0, out_data}, 32'h33);
            chk("bp_hold_valid", {31'h0, out_valid}, 32'h1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Enable freeze during load and during send
        v = '{OP_ADD, 32'h11111111, 32'h22222222, 32'h33333333, 4'b0000, 2};
        push_exp(v);
        drive_beat(8'h11, OP_ADD);
        drive_beat(8'h11, 3'd6);
        ena      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            chk("ena0_in_ready", {31'h0, in_ready}, 32'h0);
            chk("ena0_busy", {31'h0, busy}, 32'h1);
        end
        @(posedge clk);
        #1;
        ena      = 1'b1;
        in_valid = 1'b0;
        drive_beat(8'h11, 3'd6);
        drive_beat(8'h11, 3'd6);
        for (int i = 0; i < 4; i++) drive_beat(8'h22, 3'd6);
        last_cyc = cyc;
        wait_out(lat);
        chk("ena_latency", lat, 2);
        @(posedge clk);
        #1;
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("ena0_out_valid", {31'h0, out_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        ena = 1'b1;
        drain();

        // Reset in the middle of a multiply
        v = '{OP_MUL, 32'h00010001, 32'h00010001, 32'h00020001, 4'b0000, 33};
        send_txn(v);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_txn(vecs[12]);
        wait_out(lat);
        chk("post_rst_latency", lat, 2);
        drain();

        // WIDTH=8 instance: FF + 01
        in_data8  = 8'hFF;
        op8       = OP_ADD;
        in_valid8 = 1'b1;
        for (int beat = 0; beat < 2; beat++) begin
            g = 0;
            forever begin
                @(negedge clk);
                if (in_ready8) break;
                g++;
                if (g > 50) begin
                    timeout_fail("w8_in_ready_wait");
                    break;
                end
            end
            @(posedge clk);
            #1;
            in_data8 = 8'h01;
            op8      = 3'd7;
        end
        in_valid8 = 1'b0;
        last_cyc  = cyc;
        g   = 0;
        lat = -1;
        forever begin
            @(negedge clk);
            if (out_valid8) begin
                lat = cyc - last_cyc + 1;
                break;
            end
            g++;
            if (g > 50) begin
                timeout_fail("w8_out_valid_wait");
                break;
            end
        end
        chk("w8_latency", lat, 2);
        chk("w8_out_data", {24'h0, out_data8}, 32'h00);
        chk("w8_flags", {28'h0, flags8}, 32'hA);
        chk("w8_busy", {31'h0, busy8}, 32'h1);
        @(posedge clk);
        #1;
        chk("w8_out_valid_after", {31'h0, out_valid8}, 32'h0);
        chk("w8_busy_after", {31'h0, busy8}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
